// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc4: 32'h0000_0000};

  // Redirect targets must be word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus: fetch stage drives the address, memory returns
// the word for that address combinationally in the same cycle.
interface if_stage_if;
  import if_stage_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr_in;

  modport master (output pc, input instr_in);
  modport slave  (input pc, output instr_in);

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble has priority over hold, hold over load.
module ifid_reg
  import if_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc4_d,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc4,
  output logic            ifid_valid
);

  ifid_t ifid_r;

  // Register update: reset to bubble, then squash, freeze or capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_r <= IFID_BUBBLE;
    end else if (bubble) begin
      ifid_r <= IFID_BUBBLE;
    end else if (hold) begin
      ifid_r <= ifid_r;
    end else begin
      ifid_r <= '{valid: 1'b1, instr: instr_d, pc4: pc4_d};
    end
  end

  assign ifid_instr = ifid_r.instr;
  assign ifid_pc4   = ifid_r.pc4;
  assign ifid_valid = ifid_r.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc4,
  output logic            ifid_valid
);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] pc_next_s;
  logic            redirect_s;
  logic            bubble_s;

  // Wraps naturally modulo 2^32.
  assign pc_plus4_s = pc_r + PC_STEP;
  assign redirect_s = branch_taken | jump;
  assign bubble_s   = redirect_s | flush;

  // Next-PC select: branch beats jump beats stall beats sequential.
  always_comb begin
    pc_next_s = pc_plus4_s;
    if (branch_taken) begin
      pc_next_s = align_target(branch_target);
    end else if (jump) begin
      pc_next_s = align_target(jump_target);
    end else if (stall) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_plus4_s;
    end
  end

  // PC register; only registered state drives the memory address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign imem.pc = pc_r;

  // A squash wins over stall inside ifid_reg, so stall can drive hold directly.
  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (stall),
    .bubble     (bubble_s),
    .instr_d    (imem.instr_in),
    .pc4_d      (pc_plus4_s),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

endmodule
